// File: rtl/fir_dac_driver.sv
`timescale 1ns/1ps
// fir_dac_driver: converts signed FIR output words to 12-bit offset binary,
// buffers them in a small FIFO and shifts each one out to a serial DAC.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no frame; waits for a buffered sample
//   S_SHIFT | cs low, 12 sclk periods, sdin changes on sclk falling edges
//   S_CS_UP | cs released for one half-period before the load strobe
//   S_LDAC  | ldac held low for one half-period
//   S_GAP   | one half-period quiet time before the next frame
//
// Frame = 24 + 3 half-periods. A sample waiting at the end of S_GAP starts
// its frame directly, so back-to-back frames are spaced exactly one frame.
module fir_dac_driver #(
  parameter int CLK_DIV    = 5,
  parameter int SHIFT      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_axis_tvalid,
  input  logic [31:0] s_axis_tdata,
  output logic        s_axis_tready,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        ldac,
  output logic        busy,
  output logic [7:0]  sat_cnt,
  output logic [7:0]  ovf_cnt
);

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] DIV_M1    = 8'(CLK_DIV - 1);
  localparam logic [4:0] HALF_LAST = 5'd23;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CS_UP, S_LDAC, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_div, w_div_nxt;
  logic [4:0]        r_half, w_half_nxt;
  logic [11:0]       r_shreg, w_shreg_nxt;
  logic              r_cs, r_sclk, r_sdin, r_ldac;
  logic              w_cs_nxt, w_sclk_nxt, w_sdin_nxt, w_ldac_nxt;
  logic              w_start, w_pop, w_tc;

  logic [11:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [7:0]        r_sat_cnt, r_ovf_cnt;

  logic signed [31:0] w_shifted;
  logic               w_clip_hi, w_clip_lo;
  logic [11:0]        w_code, w_head;
  logic               w_full, w_empty, w_push, w_drop;

  assign w_shifted = $signed(s_axis_tdata) >>> SHIFT;
  assign w_clip_hi = (w_shifted > 32'sd2047);
  assign w_clip_lo = (w_shifted < -32'sd2048);

  // Clip to the 12-bit two's complement range, then flip the sign bit for offset binary
  always_comb begin
    w_code = {~w_shifted[11], w_shifted[10:0]};
    if (w_clip_hi)      w_code = 12'hFFF;
    else if (w_clip_lo) w_code = 12'h000;
  end

  assign w_full        = (r_count == FULL_CNT);
  assign w_empty       = (r_count == '0);
  assign s_axis_tready = ~w_full;
  assign w_push        = s_axis_tvalid & ~w_full;
  assign w_drop        = s_axis_tvalid & w_full;
  assign w_head        = r_mem[r_rd_ptr];

  // Sample storage; contents need no reset because r_count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_code;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating clip and drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_push && (w_clip_hi || w_clip_lo) && (r_sat_cnt != 8'hFF))
        r_sat_cnt <= r_sat_cnt + 8'd1;
      if (w_drop && (r_ovf_cnt != 8'hFF))
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  // Next-state and next-output logic; r_div is a half-period down-counter
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_half_nxt  = r_half;
    w_shreg_nxt = r_shreg;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_sdin_nxt  = r_sdin;
    w_ldac_nxt  = r_ldac;
    w_start     = 1'b0;
    w_tc        = (r_div == 8'd0);
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_start = 1'b1;
      end
      S_SHIFT: begin
        if (!w_tc) begin
          w_div_nxt = r_div - 8'd1;
        end else begin
          w_div_nxt = DIV_M1;
          if (r_half == 5'd0) begin
            w_state_nxt = S_CS_UP;
            w_cs_nxt    = 1'b1;
            w_sclk_nxt  = 1'b0;
            w_sdin_nxt  = 1'b0;
          end else begin
            w_half_nxt = r_half - 5'd1;
            w_sclk_nxt = ~r_sclk;
            if (r_sclk) begin
              w_shreg_nxt = {r_shreg[10:0], 1'b0};
              w_sdin_nxt  = r_shreg[10];
            end
          end
        end
      end
      S_CS_UP: begin
        if (!w_tc) begin
          w_div_nxt = r_div - 8'd1;
        end else begin
          w_div_nxt   = DIV_M1;
          w_ldac_nxt  = 1'b0;
          w_state_nxt = S_LDAC;
        end
      end
      S_LDAC: begin
        if (!w_tc) begin
          w_div_nxt = r_div - 8'd1;
        end else begin
          w_div_nxt   = DIV_M1;
          w_ldac_nxt  = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (!w_tc)         w_div_nxt = r_div - 8'd1;
        else if (!w_empty) w_start = 1'b1;
        else               w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_start) begin
      w_state_nxt = S_SHIFT;
      w_div_nxt   = DIV_M1;
      w_half_nxt  = HALF_LAST;
      w_shreg_nxt = w_head;
      w_cs_nxt    = 1'b0;
      w_sclk_nxt  = 1'b0;
      w_sdin_nxt  = w_head[11];
    end
    w_pop = w_start;
  end

  // State and registered DAC pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_div   <= DIV_M1;
      r_half  <= '0;
      r_shreg <= '0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_sdin  <= 1'b0;
      r_ldac  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_half  <= w_half_nxt;
      r_shreg <= w_shreg_nxt;
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdin  <= w_sdin_nxt;
      r_ldac  <= w_ldac_nxt;
    end
  end

  assign cs      = r_cs;
  assign sclk    = r_sclk;
  assign sdin    = r_sdin;
  assign ldac    = r_ldac;
  assign busy    = (r_state != S_IDLE);
  assign sat_cnt = r_sat_cnt;
  assign ovf_cnt = r_ovf_cnt;

endmodule
